// File: rtl/game_sched_if.sv
// game_sched_if: handshake and board-RAM bus between the game sequencer and its surroundings.
interface game_sched_if #(parameter int SCORE_W = 16);
   logic               start;
   logic               bottom_flag;
   logic               top_flag;
   logic [31:0]        piece_xy;
   logic [9:0]         row_rdata;
   logic               gen_flag;
   logic               drop_tick;
   logic               move_en;
   logic [3:0]         row_addr;
   logic               row_we;
   logic [9:0]         row_wdata;
   logic [7:0]         lines_total;
   logic [SCORE_W-1:0] score;
   logic               game_over;
   logic [2:0]         state;
   modport master (output start, bottom_flag, top_flag, piece_xy, row_rdata,
                   input gen_flag, drop_tick, move_en, row_addr, row_we, row_wdata,
                   lines_total, score, game_over, state);
   modport slave  (input start, bottom_flag, top_flag, piece_xy, row_rdata,
                   output gen_flag, drop_tick, move_en, row_addr, row_we, row_wdata,
                   lines_total, score, game_over, state);
endinterface

// File: rtl/game_sched.sv
// game_sched: Tetris game sequencer - board clear, spawn, gravity, lock, line scan/collapse, scoring.
module game_sched #(
   parameter int TICK_DIV = 25000000,
   parameter int SCORE_W  = 16
) (
   input logic         Clk,
   input logic         Reset,
   game_sched_if.slave bus
);
   localparam int GW = $clog2(TICK_DIV);
   localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, SPAWN = 3'd2, PLAY = 3'd3,
                          LOCK = 3'd4, SCAN = 3'd5, SHIFT = 3'd6, OVER = 3'd7;
   logic [2:0]         st;
   logic [3:0]         cnt, r, s;
   logic               ph;
   logic [9:0]         buf_q;
   logic [2:0]         lcnt;
   logic [GW-1:0]      gcnt;
   logic [31:0]        pxy;
   logic [7:0]         lines_q;
   logic [SCORE_W-1:0] score_q;
   logic [3:0]         xk, yk, pts;
   logic               cell_ok, full, tick_hit;
   logic [8:0]         lsum;
   always_comb begin
      xk       = pxy[(5'd31 - {cnt[1:0], 3'b000}) -: 4];
      yk       = pxy[(5'd27 - {cnt[1:0], 3'b000}) -: 4];
      cell_ok  = (xk < 4'd10) && (yk < 4'd12);
      full     = bus.row_rdata == 10'h3FF;
      tick_hit = gcnt == GW'(TICK_DIV - 1);
      lsum     = {1'b0, lines_q} + {6'b0, lcnt};
      pts      = lcnt == 3'd0 ? 4'd0 : lcnt == 3'd1 ? 4'd1 : lcnt == 3'd2 ? 4'd3 :
                 lcnt == 3'd3 ? 4'd5 : 4'd8;
      bus.gen_flag    = st == SPAWN;
      bus.move_en     = st == PLAY;
      bus.drop_tick   = st == PLAY && !bus.bottom_flag && tick_hit;
      bus.game_over   = st == OVER;
      bus.state       = st;
      bus.lines_total = lines_q;
      bus.score       = score_q;
   end
   // Board RAM port: writes happen only in CLEAR, LOCK and SHIFT write phases
   always_comb begin
      bus.row_addr  = 4'd0;
      bus.row_we    = 1'b0;
      bus.row_wdata = 10'd0;
      case (st)
         CLEAR: begin
            bus.row_addr = cnt;
            bus.row_we   = 1'b1;
         end
         LOCK: begin
            bus.row_addr  = cell_ok ? yk : 4'd0;
            bus.row_we    = cell_ok;
            bus.row_wdata = bus.row_rdata | (10'd1 << xk);
         end
         SCAN: bus.row_addr = r;
         SHIFT: begin
            bus.row_addr  = s == 4'd11 ? 4'd11 : ph ? s : s + 4'd1;
            bus.row_we    = s == 4'd11 || ph;
            bus.row_wdata = s == 4'd11 ? 10'd0 : buf_q;
         end
         default: ;
      endcase
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         st      <= IDLE;
         cnt     <= '0;
         r       <= '0;
         s       <= '0;
         ph      <= 1'b0;
         buf_q   <= '0;
         lcnt    <= '0;
         gcnt    <= '0;
         pxy     <= '0;
         lines_q <= '0;
         score_q <= '0;
      end else begin
         case (st)
            IDLE, OVER: if (bus.start) begin
               st      <= CLEAR;
               cnt     <= '0;
               score_q <= '0;
               lines_q <= '0;
            end
            CLEAR: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd11) st <= SPAWN;
            end
            SPAWN: begin
               gcnt <= '0;
               lcnt <= '0;
               st   <= PLAY;
            end
            PLAY: if (bus.bottom_flag) begin
               st  <= bus.top_flag ? OVER : LOCK;
               cnt <= '0;
               pxy <= bus.piece_xy;
            end else gcnt <= tick_hit ? '0 : gcnt + 1'b1;
            LOCK: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd3) begin
                  st <= SCAN;
                  r  <= '0;
               end
            end
            SCAN: if (full) begin
               st   <= SHIFT;
               s    <= r;
               ph   <= 1'b0;
               lcnt <= lcnt + 3'd1;
            end else if (r == 4'd11) begin
               score_q <= score_q + SCORE_W'(pts);
               lines_q <= lsum[8] ? 8'hFF : lsum[7:0];
               st      <= SPAWN;
            end else r <= r + 4'd1;
            SHIFT: if (s == 4'd11) st <= SCAN;
            else if (!ph) begin
               buf_q <= bus.row_rdata;
               ph    <= 1'b1;
            end else begin
               s  <= s + 4'd1;
               ph <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_game_sched.sv
// tb_game_sched: directed + randomized landings against a row-list board model with scoring.
module tb_game_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int passed = 0;
   int total = 0;
   int m_score = 0;
   int m_lines = 0;
   logic [9:0] mem [12];
   logic       tb_we = 1'b0;
   logic [3:0] tb_addr = 4'd0;
   logic [9:0] tb_data = 10'd0;
   game_sched_if #(.SCORE_W(16)) bus();
   game_sched #(.TICK_DIV(8), .SCORE_W(16)) dut (.Clk(clk), .Reset(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   assign bus.row_rdata = (bus.row_addr < 4'd12) ? mem[bus.row_addr] : 10'h0;
   always @(posedge clk) begin
      if (bus.row_we && bus.row_addr < 4'd12) mem[bus.row_addr] <= bus.row_wdata;
      else if (tb_we) mem[tb_addr] <= tb_data;
   end
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   task automatic poke(input int a, input logic [9:0] d);
      tb_addr = 4'(a);
      tb_data = d;
      tb_we   = 1'b1;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask
   task automatic clear_seq();
      logic [9:0] any;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      m_score = 0;
      m_lines = 0;
      chk("clear_entry_state", bus.state, 3'd1);
      chk("clear_entry_score", bus.score, 16'd0);
      chk("clear_entry_lines", bus.lines_total, 8'd0);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("clear_wr%0d", i), {bus.row_we, bus.row_addr, bus.row_wdata, bus.gen_flag},
             {1'b1, 4'(i), 10'h0, 1'b0});
         @(negedge clk);
      end
      chk("spawn_gen", {bus.gen_flag, bus.row_we}, 2'b10);
      @(negedge clk);
      chk("play_after_spawn", {bus.gen_flag, bus.state, bus.move_en}, {1'b0, 3'd3, 1'b1});
      any = 10'h0;
      for (int i = 0; i < 12; i++) any |= mem[i];
      chk("board_cleared", any, 10'h0);
   endtask
   task automatic land(input logic [31:0] p, input bit top, input bit noise);
      logic [9:0] b [12];
      logic [9:0] keep [$];
      int nv, nfull, wr, sc, n, pts;
      logic [3:0] x, y;
      bit bad;
      nv = 0;
      for (int r = 0; r < 12; r++) b[r] = mem[r];
      for (int k = 0; k < 4; k++) begin
         x = p[31 - 8*k -: 4];
         y = p[27 - 8*k -: 4];
         if (x < 10 && y < 12) begin
            b[y] |= 10'(1 << x);
            nv++;
         end
      end
      nfull = 0;
      keep = {};
      for (int r = 0; r < 12; r++) if (b[r] == 10'h3FF) nfull++; else keep.push_back(b[r]);
      while (keep.size() < 12) keep.push_back(10'h0);
      pts = nfull == 0 ? 0 : nfull == 1 ? 1 : nfull == 2 ? 3 : nfull == 3 ? 5 : 8;
      chk("land_in_play", bus.state, 3'd3);
      bus.piece_xy    = p;
      bus.bottom_flag = 1'b1;
      bus.top_flag    = top;
      #1;
      chk("no_tick_on_land", bus.drop_tick, 1'b0);
      @(negedge clk);
      bus.top_flag    = 1'b0;
      bus.bottom_flag = noise ? 1'($urandom) : 1'b0;
      if (top) begin
         bus.bottom_flag = 1'b0;
         chk("over_state", {bus.state, bus.game_over, bus.move_en}, {3'd7, 1'b1, 1'b0});
         bad = 0;
         for (int i = 0; i < 6; i++) begin
            if (bus.gen_flag || bus.row_we || bus.state != 3'd7) bad = 1;
            @(negedge clk);
         end
         chk("over_quiet", bad, 1'b0);
         return;
      end
      wr = 0;
      sc = 0;
      for (n = 0; n < 400; n++) begin
         if (bus.state == 3'd4 && bus.row_we) wr++;
         if (bus.state == 3'd5) sc++;
         if (bus.gen_flag) break;
         bus.bottom_flag = noise ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end
      bus.bottom_flag = 1'b0;
      chk("land_timeout", n < 400, 1'b1);
      chk("lock_writes", wr, nv);
      if (nfull == 0) chk("scan_len", sc, 12);
      for (int r = 0; r < 12; r++) chk($sformatf("row%0d", r), mem[r], keep[r]);
      m_score = (m_score + pts) % 65536;
      m_lines = m_lines + nfull > 255 ? 255 : m_lines + nfull;
      chk("score", bus.score, m_score);
      chk("lines_total", bus.lines_total, m_lines);
      @(negedge clk);
      chk("gen_one_cycle", {bus.gen_flag, bus.state}, {1'b0, 3'd3});
   endtask
   initial begin
      int ticks, last, first;
      bit gap_bad, mv_bad;
      logic [9:0] rows [12];
      logic [3:0] h [12];
      logic [31:0] p;
      logic [3:0] x, y;
      bus.start = 1'b0;
      bus.bottom_flag = 1'b0;
      bus.top_flag = 1'b0;
      bus.piece_xy = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_state", bus.state, 3'd0);
      chk("rst_outs", {bus.gen_flag, bus.drop_tick, bus.move_en, bus.row_we, bus.game_over},
          5'b0);
      chk("rst_counters", {bus.score, bus.lines_total, bus.row_addr, bus.row_wdata}, 38'h0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) poke(i, 10'($urandom));
      chk("idle_holds", bus.state, 3'd0);
      clear_seq();
      // Gravity: first PLAY cycle has the counter at 0, so ticks land on cycles 7,15,...
      ticks = 0; last = -1; first = -1; gap_bad = 0; mv_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.drop_tick) begin
            ticks++;
            if (last >= 0 && i - last != 8) gap_bad = 1;
            if (first < 0) first = i;
            last = i;
         end
         if (!bus.move_en) mv_bad = 1;
         @(negedge clk);
      end
      chk("tick_count", ticks, 5);
      chk("tick_first", first, 7);
      chk("tick_gap", gap_bad, 1'b0);
      chk("move_en_play", mv_bad, 1'b0);
      land(32'h40506070, 1'b0, 1'b0);
      chk("line_row0", mem[0], 10'h0F0);
      for (int i = 0; i < 12; i++) poke(i, i < 2 ? 10'h1FF : i < 4 ? 10'h200 : 10'h0);
      land(32'h90919293, 1'b0, 1'b1);
      chk("two_clear_score", bus.score, 16'd3);
      chk("two_clear_lines", bus.lines_total, 8'd2);
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 12; i++) begin
            h[i] = 4'($urandom_range(0, 9));
            rows[i] = ($urandom % 3 == 0) ? 10'h0 : 10'h3FF & ~10'(1 << h[i]);
            poke(i, rows[i]);
         end
         for (int k = 0; k < 4; k++) begin
            y = 4'($urandom_range(0, 11));
            x = ($urandom % 2) ? h[y] : 4'($urandom_range(0, 9));
            if ($urandom % 8 == 0) x = 4'($urandom_range(10, 15));
            if ($urandom % 10 == 0) y = 4'($urandom_range(12, 15));
            p[31 - 8*k -: 8] = {x, y};
         end
         land(p, 1'b0, 1'($urandom));
      end
      land(32'h4B5B6B7B, 1'b1, 1'b0);
      clear_seq();
      poke(0, 10'h1FF);
      bus.piece_xy = 32'h90FFFFFF;
      bus.bottom_flag = 1'b1;
      @(negedge clk);
      bus.bottom_flag = 1'b0;
      for (int i = 0; i < 20 && bus.state != 3'd6; i++) @(negedge clk);
      chk("reach_shift", bus.state, 3'd6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_shift", {bus.state, bus.row_we, bus.gen_flag, bus.score}, 21'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_idle", bus.state, 3'd0);
      clear_seq();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/game_sched.md
Name: game_sched

Overview:
- Top-level sequencer for one Tetris game. It owns the 12-row x 10-column settled-board RAM and drives the piece generator's spawn pulse and gravity tick.
- After the generator reports a landed piece, it locks the four cells into the board, scans for full rows, collapses them, scores, and respawns.
- It also gates player moves so they are accepted only during active play, and detects game over.

Parameters:
- TICK_DIV, 25000000, clocks per gravity tick (benches use 8); legal range >= 2.
- SCORE_W, 16, score counter width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- Start  in  1  level; starts or restarts a game from IDLE or OVER
- bottom_flag  in  1  generator reports the piece has landed
- top_flag  in  1  generator reports the landed piece touches row 11
- piece_xy  in  32  {x1,y1,x2,y2,x3,y3,x4,y4}, 4 bits each, landed piece cells
- row_rdata  in  10  board RAM combinational read data at row_addr; bit i = column i
- gen_flag  out  1  one-cycle spawn request to the generator
- drop_tick  out  1  one-cycle gravity pulse
- move_en  out  1  high only in PLAY; gates the U/L/R button pulses upstream
- row_addr  out  4  board RAM address, rows 0..11
- row_we  out  1  board RAM write enable
- row_wdata  out  10  board RAM write data
- lines_total  out  8  rows cleared this game, saturating at 255
- score  out  SCORE_W  game score, wraps modulo 2^SCORE_W
- game_over  out  1  high in OVER
- state  out  3  encoded state for debug

Behaviour:
- State encoding: IDLE=0, CLEAR=1, SPAWN=2, PLAY=3, LOCK=4, SCAN=5, SHIFT=6, OVER=7.
- Reset: state=IDLE. All outputs 0, including lines_total, score and all internal counters. Reset mid-operation aborts immediately; a partial board write is acceptable because CLEAR rewrites the board.
- IDLE: if Start, go to CLEAR.
- CLEAR:
  - 12 cycles writing row_we=1, row_wdata=0, row_addr=0..11.
  - On entry, zero lines_total and score.
  - Then go to SPAWN.
- SPAWN:
  - gen_flag=1 for exactly one cycle.
  - Zero the gravity counter and the per-lock line count (lcnt).
  - Go to PLAY.
- PLAY:
  - move_en=1.
  - The gravity counter increments each cycle. drop_tick=1 on the cycle the counter equals TICK_DIV-1, and the counter wraps to 0 on that cycle.
  - If bottom_flag=1 and top_flag=1, go to OVER; this takes priority.
  - Else if bottom_flag=1, go to LOCK with k=0; no drop_tick is issued that cycle.
  - bottom_flag is ignored in every state other than PLAY.
- LOCK:
  - Four cycles, k=0..3.
  - row_addr=y_k, row_we=1, row_wdata=row_rdata | (1<<x_k).
  - Two cells in the same row are correct because each write commits at the clock edge before the next read.
  - A cell with x_k>9 or y_k>11 is skipped: row_we=0 that cycle.
  - After k=3, go to SCAN with r=0.
- SCAN:
  - row_addr=r, row_we=0.
  - If row_rdata==10'h3FF, go to SHIFT with s=r, and increment lcnt.
  - Else if r==11, finish the scan: score += table[lcnt] (0->0, 1->1, 2->3, 3->5, 4->8); lines_total += lcnt, saturating; go to SPAWN.
  - Else r <= r+1.
- SHIFT: two cycles per row.
  - Read phase: row_addr=s+1; latch row_rdata into a buffer.
  - Write phase: row_addr=s, row_we=1, row_wdata=buffer; then s <= s+1.
  - When s==11, do one write cycle of row 11 = 0, then return to SCAN with r unchanged, so the collapsed row is rescanned.
- OVER: game_over=1, move_en=0. If Start, go to CLEAR.
- row_we=0 in every state except CLEAR, LOCK and SHIFT write cycles.
- Widths: row_addr arithmetic is 4-bit. No address above 11 is ever driven.

Test Plan:
- Reset mid-SHIFT -> next cycle state=0, row_we=0, gen_flag=0, score=0. Start=1 -> 12 CLEAR writes of 0 to rows 0..11, then gen_flag high exactly one cycle.
- TICK_DIV=8, PLAY with no bottom_flag for 40 cycles -> drop_tick pulses exactly 5 times, 8 cycles apart; move_en=1 throughout.
- Board empty; land a LINE piece at (4..7,0) -> 4 LOCK writes; row 0 ends at 10'h0F0; no clear; score stays 0; gen_flag pulses once after the 12-row SCAN.
- Rows 0 and 1 preloaded to 10'h3FF except column 9 in each; vertical piece fills (9,0),(9,1),(9,2),(9,3) -> both rows cleared; former rows 2,3 data (10'h200 each) now in rows 0,1; rows 10,11 = 0; lines_total=2; score=3.
- bottom_flag=1 with top_flag=1 in PLAY -> state=OVER, game_over=1, no LOCK writes, no gen_flag. Start -> CLEAR and score reset to 0.
- bottom_flag asserted during SCAN -> ignored; the scan completes and the next SPAWN occurs normally.
